// File: rtl/bomber_sprite_pkg.sv
// Shared types and constants for the bird sprite scheduler.
// Latency: n/a (declarations plus one combinational helper function).
// Backpressure: n/a.
package bomber_sprite_pkg;

    localparam int SPR       = 32;             // sprite edge in pixels
    localparam int IDXW      = 10;             // palette index width
    localparam int H_MAX     = 640;            // horizontal screen limit
    localparam int CW        = 10;             // screen coordinate width
    localparam int CW1       = CW + 1;         // coordinate width plus carry
    localparam int OFFW      = $clog2(SPR);    // in-sprite offset width
    localparam int FRAME_DIV = 8;              // frames per wing-flap toggle
    localparam int ANIM_W    = $clog2(FRAME_DIV);

    typedef struct packed {
        logic              active;
        logic [CW-1:0]     x;
        logic [CW-1:0]     y;
        logic              dir;       // 1 = moving right, 0 = moving left
        logic [ANIM_W-1:0] anim_cnt;
        logic              frame;
    } bird_slot_t;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } sched_state_t;

    // One video frame of motion and animation for a single slot. A bird that
    // would step past the screen edge is retired instead of moved.
    function automatic bird_slot_t bird_advance(input bird_slot_t s, input int step);
        bird_slot_t n;
        n = s;
        if (s.active) begin
            if (s.dir) begin
                // carry bit keeps an out-of-range spawn_x from wrapping back on screen
                if (({1'b0, s.x} + CW1'(step)) > CW1'(H_MAX - SPR)) begin
                    n.active = 1'b0;
                end else begin
                    n.x = s.x + CW'(step);
                end
            end else begin
                if (s.x < CW'(step)) begin
                    n.active = 1'b0;
                end else begin
                    n.x = s.x - CW'(step);
                end
            end
            if (s.anim_cnt == ANIM_W'(FRAME_DIV - 1)) begin
                n.anim_cnt = '0;
                n.frame    = ~s.frame;
            end else begin
                n.anim_cnt = s.anim_cnt + ANIM_W'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bird_slot_hit.sv
// Per-slot hit test: does the current pixel fall inside this bird, and where.
// Latency: combinational.
// Backpressure: none.
// Ports: i_slot (slot registers), i_draw_x/i_draw_y (current pixel),
//        o_hit (pixel inside active bird), o_row/o_col (ROM address, col mirrored for left birds).
module bird_slot_hit
    import bomber_sprite_pkg::*;
(
    input  bird_slot_t      i_slot,
    input  logic [CW-1:0]   i_draw_x,
    input  logic [CW-1:0]   i_draw_y,
    output logic            o_hit,
    output logic [OFFW-1:0] o_row,
    output logic [OFFW-1:0] o_col
);

    logic [CW-1:0] w_dx;
    logic [CW-1:0] w_dy;
    logic          w_unused_slot;

    // Unsigned differences: a pixel left of / above the bird wraps to a large
    // value and fails the range compare, so one compare covers both sides.
    assign w_dx  = i_draw_x - i_slot.x;
    assign w_dy  = i_draw_y - i_slot.y;
    assign o_hit = i_slot.active && (w_dx < CW'(SPR)) && (w_dy < CW'(SPR));
    assign o_row = w_dy[OFFW-1:0];
    // Left-moving birds reuse the same ROM, read back to front.
    assign o_col = i_slot.dir ? w_dx[OFFW-1:0] : (OFFW'(SPR - 1) - w_dx[OFFW-1:0]);

    // Animation state is not needed for the geometric test.
    assign w_unused_slot = ^{i_slot.anim_cnt, i_slot.frame};

endmodule

// File: rtl/bird_sprite_sched.sv
// Bird slot scheduler: spawns birds, advances them once per video frame, and
// resolves each pixel to one owning bird driving the shared sprite ROM.
// Latency: px_valid -> rom_* 1 cycle, px_valid -> pix_* 2 cycles, one pixel per cycle.
// Backpressure: spawn_ready low while updating or when all slots are full; pixels never stall.
// Ports: i_clk/i_rst_n; i_frame_start; spawn i_spawn_valid/o_spawn_ready/i_spawn_x/y/dir;
//        pixel i_px_valid/i_draw_x/y; ROM o_rom_frame/row/col, i_rom_data;
//        result o_pix_valid/o_pix_hit/o_pix_idx; o_active_mask.
module bird_sprite_sched
    import bomber_sprite_pkg::*;
#(
    parameter int N_BIRDS = 4,
    parameter int STEP    = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_start,
    input  logic               i_spawn_valid,
    output logic               o_spawn_ready,
    input  logic [CW-1:0]      i_spawn_x,
    input  logic [CW-1:0]      i_spawn_y,
    input  logic               i_spawn_dir,
    input  logic               i_px_valid,
    input  logic [CW-1:0]      i_draw_x,
    input  logic [CW-1:0]      i_draw_y,
    output logic               o_rom_frame,
    output logic [OFFW-1:0]    o_rom_row,
    output logic [OFFW-1:0]    o_rom_col,
    input  logic [IDXW-1:0]    i_rom_data,
    output logic               o_pix_valid,
    output logic               o_pix_hit,
    output logic [IDXW-1:0]    o_pix_idx,
    output logic [N_BIRDS-1:0] o_active_mask
);

    localparam int KW = (N_BIRDS > 1) ? $clog2(N_BIRDS) : 1;

    sched_state_t    r_state;
    sched_state_t    w_state_nxt;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   w_k_nxt;

    bird_slot_t      r_slot     [N_BIRDS];
    bird_slot_t      w_slot_nxt [N_BIRDS];

    logic            w_any_free;
    logic [KW-1:0]   w_free_idx;
    logic            w_spawn_fire;

    logic [N_BIRDS-1:0] w_hit;
    logic [OFFW-1:0]    w_row [N_BIRDS];
    logic [OFFW-1:0]    w_col [N_BIRDS];
    logic               w_win_hit;
    logic [OFFW-1:0]    w_win_row;
    logic [OFFW-1:0]    w_win_col;
    logic               w_win_frame;

    logic            r_s1_vld;
    logic            r_s1_hit;
    logic            r_rom_frame;
    logic [OFFW-1:0] r_rom_row;
    logic [OFFW-1:0] r_rom_col;
    logic            r_pix_vld;
    logic            r_pix_hit;
    logic [IDXW-1:0] r_pix_idx;

    // ---------------------------------------------------------------- spawn
    // Lowest-index free slot; scanning downward lets the lowest match win.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = N_BIRDS - 1; i >= 0; i--) begin
            if (!r_slot[i].active) begin
                w_any_free = 1'b1;
                w_free_idx = KW'(i);
            end
        end
    end

    // Gated with the reset pin so no spawn is offered while reset is held.
    assign o_spawn_ready = i_rst_n && (r_state == IDLE) && w_any_free;
    assign w_spawn_fire  = i_spawn_valid && o_spawn_ready;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        case (r_state)
            IDLE: begin
                w_k_nxt = '0;
                if (i_frame_start) begin
                    w_state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                // frame_start is deliberately not looked at here
                if (r_k == KW'(N_BIRDS - 1)) begin
                    w_state_nxt = IDLE;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------- slots
    // Spawns only happen in IDLE and updates only in UPDATE, so the two
    // writers never target the slot array in the same cycle. A spawn taken
    // together with frame_start lands before the first update visit.
    always_comb begin
        for (int i = 0; i < N_BIRDS; i++) begin
            w_slot_nxt[i] = r_slot[i];
        end
        if (w_spawn_fire) begin
            w_slot_nxt[w_free_idx] = '{active:   1'b1,
                                       x:        i_spawn_x,
                                       y:        i_spawn_y,
                                       dir:      i_spawn_dir,
                                       anim_cnt: '0,
                                       frame:    1'b0};
        end else if (r_state == UPDATE) begin
            w_slot_nxt[r_k] = bird_advance(r_slot[r_k], STEP);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_BIRDS; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BIRDS; i++) begin
                r_slot[i] <= w_slot_nxt[i];
            end
        end
    end

    always_comb begin
        o_active_mask = '0;
        for (int i = 0; i < N_BIRDS; i++) begin
            o_active_mask[i] = r_slot[i].active;
        end
    end

    // -------------------------------------------------------- hit + priority
    for (genvar g = 0; g < N_BIRDS; g++) begin : g_hit
        bird_slot_hit u_hit (
            .i_slot   (r_slot[g]),
            .i_draw_x (i_draw_x),
            .i_draw_y (i_draw_y),
            .o_hit    (w_hit[g]),
            .o_row    (w_row[g]),
            .o_col    (w_col[g])
        );
    end

    // The lowest hitting slot owns the pixel even if its texel turns out to be
    // transparent; birds underneath are never consulted.
    always_comb begin
        w_win_hit   = 1'b0;
        w_win_row   = '0;
        w_win_col   = '0;
        w_win_frame = 1'b0;
        for (int i = N_BIRDS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_win_hit   = 1'b1;
                w_win_row   = w_row[i];
                w_win_col   = w_col[i];
                w_win_frame = r_slot[i].frame;
            end
        end
    end

    // ------------------------------------------------------------- pipeline
    // Stage 1: ROM address. Updated only on a pixel strobe (zero on a miss),
    // held otherwise so an idle ROM input does not toggle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_hit    <= 1'b0;
            r_rom_frame <= 1'b0;
            r_rom_row   <= '0;
            r_rom_col   <= '0;
        end else begin
            r_s1_vld <= i_px_valid;
            if (i_px_valid) begin
                r_s1_hit    <= w_win_hit;
                r_rom_frame <= w_win_frame;
                r_rom_row   <= w_win_row;
                r_rom_col   <= w_win_col;
            end else begin
                r_s1_hit    <= 1'b0;
            end
        end
    end

    // Stage 2: capture the ROM answer; palette index 0 doubles as "no bird".
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_vld <= 1'b0;
            r_pix_hit <= 1'b0;
            r_pix_idx <= '0;
        end else begin
            r_pix_vld <= r_s1_vld;
            r_pix_idx <= r_s1_hit ? i_rom_data : '0;
            r_pix_hit <= r_s1_hit && (i_rom_data != '0);
        end
    end

    assign o_rom_frame = r_rom_frame;
    assign o_rom_row   = r_rom_row;
    assign o_rom_col   = r_rom_col;
    assign o_pix_valid = r_pix_vld;
    assign o_pix_hit   = r_pix_hit;
    assign o_pix_idx   = r_pix_idx;

endmodule

// File: tb/tb_bird_sprite_sched.sv
// Bench for bird_sprite_sched: directed boundary cases plus random traffic,
// all outputs compared every cycle against a behavioural model of the birds.
// Latency/backpressure: n/a.
module tb_bird_sprite_sched;

    localparam int NB    = 4;
    localparam int SPRT  = 32;
    localparam int HMAX  = 640;
    localparam int STEPT = 2;
    localparam int FDIV  = 8;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;
    logic       spawn_dir;
    logic       px_valid;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic       rom_frame;
    logic [4:0] rom_row;
    logic [4:0] rom_col;
    logic [9:0] rom_data;
    logic       pix_valid;
    logic       pix_hit;
    logic [9:0] pix_idx;
    logic [3:0] active_mask;

    int checks = 0;
    int errors = 0;

    bird_sprite_sched #(.N_BIRDS(NB), .STEP(STEPT)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .i_spawn_valid (spawn_valid),
        .o_spawn_ready (spawn_ready),
        .i_spawn_x     (spawn_x),
        .i_spawn_y     (spawn_y),
        .i_spawn_dir   (spawn_dir),
        .i_px_valid    (px_valid),
        .i_draw_x      (draw_x),
        .i_draw_y      (draw_y),
        .o_rom_frame   (rom_frame),
        .o_rom_row     (rom_row),
        .o_rom_col     (rom_col),
        .i_rom_data    (rom_data),
        .o_pix_valid   (pix_valid),
        .o_pix_hit     (pix_hit),
        .o_pix_idx     (pix_idx),
        .o_active_mask (active_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM stand-in: a diagonal stripe pattern of transparent texels.
    function automatic logic [9:0] rom_fn(input logic f, input logic [4:0] r, input logic [4:0] c);
        int v;
        if (((int'(r) + int'(c)) % 7) == 3) return 10'd0;
        v = (f ? 512 : 0) + int'(r) * 16 + int'(c) + 1;
        return v[9:0];
    endfunction

    assign rom_data = rom_fn(rom_frame, rom_row, rom_col);

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    bit m_act  [NB];
    int m_x    [NB];
    int m_y    [NB];
    bit m_dir  [NB];
    int m_nupd [NB];   // frames survived since spawn
    int upd_left = 0;  // slots still to be visited in the current update pass

    int e_rom_row = 0;
    int e_rom_col = 0;
    int e_rom_frame = 0;
    bit e_s1_vld = 0;
    bit e_s1_hit = 0;
    bit e_pix_vld = 0;
    int e_pix_idx = 0;

    int mo_owner, mo_dx, mo_dy, mo_k, mo_free;

    function automatic int exp_mask();
        int v = 0;
        for (int i = 0; i < NB; i++) if (m_act[i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int exp_ready();
        if (!rst_n || upd_left != 0) return 0;
        for (int i = 0; i < NB; i++) if (!m_act[i]) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_nupd[i] = 0;
            end
            upd_left = 0;
            e_rom_row = 0; e_rom_col = 0; e_rom_frame = 0;
            e_s1_vld = 0; e_s1_hit = 0; e_pix_vld = 0; e_pix_idx = 0;
        end else begin
            // result stage sees the address presented during the previous cycle
            e_pix_vld = e_s1_vld;
            e_pix_idx = (e_s1_vld && e_s1_hit) ?
                        int'(rom_fn(e_rom_frame[0], 5'(e_rom_row), 5'(e_rom_col))) : 0;
            if (px_valid) begin
                mo_owner = -1;
                for (int k = 0; k < NB; k++) begin
                    mo_dx = (int'(draw_x) - m_x[k] + 1024) % 1024;
                    mo_dy = (int'(draw_y) - m_y[k] + 1024) % 1024;
                    if (mo_owner < 0 && m_act[k] && mo_dx < SPRT && mo_dy < SPRT) begin
                        mo_owner    = k;
                        e_rom_row   = mo_dy;
                        e_rom_col   = m_dir[k] ? mo_dx : (SPRT - 1 - mo_dx);
                        e_rom_frame = (m_nupd[k] / FDIV) % 2;
                    end
                end
                e_s1_vld = 1;
                e_s1_hit = (mo_owner >= 0);
                if (mo_owner < 0) begin
                    e_rom_row = 0; e_rom_col = 0; e_rom_frame = 0;
                end
            end else begin
                e_s1_vld = 0;
                e_s1_hit = 0;
            end
            if (upd_left > 0) begin
                mo_k = NB - upd_left;
                if (m_act[mo_k]) begin
                    if (m_dir[mo_k]) begin
                        if (m_x[mo_k] + STEPT > HMAX - SPRT) m_act[mo_k] = 0;
                        else m_x[mo_k] = m_x[mo_k] + STEPT;
                    end else begin
                        if (m_x[mo_k] < STEPT) m_act[mo_k] = 0;
                        else m_x[mo_k] = m_x[mo_k] - STEPT;
                    end
                    m_nupd[mo_k]++;
                end
                upd_left--;
            end else begin
                if (spawn_valid) begin
                    mo_free = -1;
                    for (int k = NB - 1; k >= 0; k--) if (!m_act[k]) mo_free = k;
                    if (mo_free >= 0) begin
                        m_act[mo_free]  = 1;
                        m_x[mo_free]    = int'(spawn_x);
                        m_y[mo_free]    = int'(spawn_y);
                        m_dir[mo_free]  = spawn_dir;
                        m_nupd[mo_free] = 0;
                    end
                end
                if (frame_start) upd_left = NB;
            end
        end
    end

    // ---------------------------------------------------------- compare
    always @(negedge clk) begin
        check("mask",      int'(active_mask), exp_mask());
        check("ready",     int'(spawn_ready), exp_ready());
        check("rom_row",   int'(rom_row),     e_rom_row);
        check("rom_col",   int'(rom_col),     e_rom_col);
        check("rom_frame", int'(rom_frame),   e_rom_frame);
        check("pix_valid", int'(pix_valid),   int'(e_pix_vld));
        check("pix_idx",   int'(pix_idx),     e_pix_idx);
        check("pix_hit",   int'(pix_hit),     (e_pix_idx != 0) ? 1 : 0);
    end

    // ----------------------------------------------------------- driver
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic spawn(input logic [9:0] x, input logic [9:0] y, input logic d);
        spawn_x = x; spawn_y = y; spawn_dir = d; spawn_valid = 1'b1;
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic fpulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (NB + 1) step();
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y,
                         input int er, input int ec, input int ef, input int eidx);
        draw_x = x; draw_y = y; px_valid = 1'b1;
        step();
        px_valid = 1'b0;
        check("lit_rom_row",   int'(rom_row),   er);
        check("lit_rom_col",   int'(rom_col),   ec);
        check("lit_rom_frame", int'(rom_frame), ef);
        step();
        check("lit_pix_valid", int'(pix_valid), 1);
        check("lit_pix_idx",   int'(pix_idx),   eidx);
        check("lit_pix_hit",   int'(pix_hit),   (eidx != 0) ? 1 : 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; frame_start = 0; spawn_valid = 0; spawn_x = 0; spawn_y = 0;
        spawn_dir = 0; px_valid = 0; draw_x = 0; draw_y = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_mask",      int'(active_mask), 0);
        check("rst_ready",     int'(spawn_ready), 0);
        check("rst_pix_valid", int'(pix_valid),   0);
        check("rst_pix_idx",   int'(pix_idx),     0);
        check("rst_rom_col",   int'(rom_col),     0);
        rst_n = 1'b1;
        step();
        check("rel_ready", int'(spawn_ready), 1);

        // right bird, plain lookup
        spawn(10'd100, 10'd50, 1'b1);
        check("spawn_mask", int'(active_mask), 1);
        step(); step();
        probe(10'd110, 10'd60, 10, 10, 0, 171);

        // left bird: mirrored column, motion and flap toggling
        do_reset();
        spawn(10'd100, 10'd50, 1'b0);
        probe(10'd100, 10'd50, 0, 31, 0, 0);
        repeat (8) fpulse();
        probe(10'd83, 10'd50, 0, 0, 0, 0);
        probe(10'd89, 10'd52, 2, 26, 1, 571);
        repeat (8) fpulse();
        probe(10'd73, 10'd52, 2, 26, 0, 59);

        // screen edges
        do_reset();
        spawn(10'd607, 10'd100, 1'b1);
        check("edge_r_pre", int'(active_mask), 1);
        fpulse();
        check("edge_r_gone", int'(active_mask), 0);
        spawn(10'd1, 10'd100, 1'b0);
        fpulse();
        check("edge_l_gone", int'(active_mask), 0);
        spawn(10'd606, 10'd100, 1'b1);
        fpulse();
        check("edge_r_608", int'(active_mask), 1);
        probe(10'd608, 10'd100, 0, 0, 0, 1);
        fpulse();
        check("edge_r_608_gone", int'(active_mask), 0);

        // full slots, fifth refused, transparent owner hides slot 2
        do_reset();
        spawn(10'd200, 10'd200, 1'b1);
        spawn(10'd400, 10'd10,  1'b1);
        spawn(10'd210, 10'd210, 1'b1);
        spawn(10'd500, 10'd300, 1'b0);
        check("full_mask",  int'(active_mask), 15);
        check("full_ready", int'(spawn_ready), 0);
        spawn(10'd0, 10'd0, 1'b1);
        check("fifth_mask", int'(active_mask), 15);
        probe(10'd0, 10'd0, 0, 0, 0, 0);
        probe(10'd210, 10'd214, 14, 10, 0, 0);

        // reset in the middle of an update pass with a pixel in flight
        frame_start = 1'b1; px_valid = 1'b1; draw_x = 10'd215; draw_y = 10'd215;
        step();
        frame_start = 1'b0; px_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("midupd_mask",      int'(active_mask), 0);
        check("midupd_pix_valid", int'(pix_valid),   0);
        step();
        rst_n = 1'b1;
        step();
        check("midupd_ready", int'(spawn_ready), 1);

        // random traffic
        repeat (3000) begin
            spawn_valid = ($urandom_range(0, 7) == 0);
            spawn_dir   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       spawn_x = 10'($urandom_range(600, 1023));
                1:       spawn_x = 10'($urandom_range(0, 5));
                default: spawn_x = 10'($urandom_range(0, 639));
            endcase
            spawn_y     = 10'($urandom_range(0, 479));
            frame_start = ($urandom_range(0, 15) == 0);
            px_valid    = 1'($urandom_range(0, 1));
            mo_k        = int'($urandom_range(0, NB - 1));
            draw_x      = 10'(m_x[mo_k] + int'($urandom_range(0, 40)) - 4);
            draw_y      = 10'(m_y[mo_k] + int'($urandom_range(0, 40)) - 4);
            step();
        end
        spawn_valid = 0; frame_start = 0; px_valid = 0;
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
